aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have no parameters; round counts are fixed by mode encoding.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  operation request; accepted when start=1 and in_ready=1 at a clk edge.
REQ-005 mode  input  2  key size: 00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=illegal.
REQ-006 decrypt  input  1  0=cipher sequence, 1=inverse-cipher sequence.
REQ-007 abort  input  1  cancel the in-flight operation.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 in_ready  output  1  high only in IDLE.
REQ-010 nr  output  4  Nr latched at accept (10/12/14).
REQ-011 rnd_idx  output  4  round-key index presented to the key-schedule word select.
REQ-012 rnd_en  output  1  datapath state-register load strobe.
REQ-013 rnd_first  output  1  initial AddRoundKey-only step.
REQ-014 rnd_last  output  1  final round; datapath omits (Inv)MixColumns.
REQ-015 dir  output  1  latched decrypt flag.
REQ-016 out_valid  output  1  result available; held until out_ready.
REQ-017 err  output  1  one-cycle pulse on illegal-mode request.

Function
REQ-018 FSM states SHALL be IDLE, INIT, ROUND, DONE.
REQ-019 IDLE: start with mode!=11 -> INIT; mode, decrypt latched into nr, dir.
REQ-020 IDLE: start with mode=11 -> stay IDLE, err=1 next cycle for one cycle, nr/dir unchanged.
REQ-021 INIT (exactly one cycle): rnd_en=1, rnd_first=1, rnd_idx=0 if dir=0 else nr; -> ROUND.
REQ-022 ROUND: rnd_en=1 each cycle; rnd_idx steps +1 (dir=0) from 1 up to nr, or -1 (dir=1) from nr-1 down to 0.
REQ-023 rnd_last=1 in the ROUND cycle with rnd_idx=nr (dir=0) or rnd_idx=0 (dir=1); next state DONE.
REQ-024 ROUND SHALL last exactly nr cycles; total rnd_en pulses per operation = nr+1.
REQ-025 DONE: out_valid=1, rnd_en=0; out_valid held while out_ready=0; out_ready=1 -> IDLE next cycle.
REQ-026 Latency: accept at edge T -> INIT during cycle T+1 -> first out_valid cycle T+nr+2.
REQ-027 rnd_en, rnd_first, rnd_last SHALL be 0 outside INIT/ROUND; rnd_first and rnd_last never both 1.
REQ-028 start while in_ready=0 SHALL be ignored, no err, no state change.
REQ-029 abort=1 in INIT, ROUND or DONE -> IDLE next edge; no out_valid afterward; rnd_en=0 from that cycle.
REQ-030 abort=1 with start=1 in IDLE: abort wins, request not accepted, no err.
REQ-031 out_ready=1 and abort=1 in DONE: -> IDLE (equivalent outcome).
REQ-032 start asserted in the IDLE cycle following DONE SHALL be accepted (back-to-back, one idle cycle minimum).
REQ-033 Round counter SHALL never wrap: no decrement below 0, no increment above nr.
REQ-034 mode/decrypt changes after accept SHALL not affect the in-flight operation.

Reset
REQ-035 rst=1 at an edge -> IDLE regardless of state, including mid-ROUND and DONE.
REQ-036 Reset values: in_ready=1, nr=10, rnd_idx=0, dir=0, rnd_en=0, rnd_first=0, rnd_last=0, out_valid=0, err=0.
REQ-037 rst has priority over start, abort, out_ready.

Verification
REQ-038 mode=00, decrypt=0, start at T, out_ready=1 -> rnd_idx 0,1..10 on cycles T+1..T+11, rnd_last at T+11, out_valid at T+12 only.
REQ-039 mode=10, decrypt=1 -> rnd_idx 14,13..0, rnd_first with idx 14, rnd_last with idx 0, 15 rnd_en pulses, out_valid at T+16.
REQ-040 mode=01, out_ready low 5 cycles in DONE -> out_valid held 6 cycles, then IDLE; start during DONE ignored.
REQ-041 mode=11 start -> err pulse one cycle, in_ready stays 1, no rnd_en.
REQ-042 abort at 4th ROUND cycle (mode=00) -> IDLE next edge, no out_valid; subsequent start completes normally.
REQ-043 rst mid-ROUND (mode=10) -> all outputs at reset values next cycle; start and abort together in IDLE -> not accepted.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps the round-key index for cipher or inverse cipher
// and produces the datapath strobes for AES-128/192/256.
module aes_round_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       decrypt,
  input  logic       abort,
  input  logic       out_ready,
  output logic       in_ready,
  output logic [3:0] nr,
  output logic [3:0] rnd_idx,
  output logic       rnd_en,
  output logic       rnd_first,
  output logic       rnd_last,
  output logic       dir,
  output logic       out_valid,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] nr_q, idx_q, mode_nr;
  logic       dir_q, err_q;
  logic       accept, illegal, at_last, step;

  // Nr = 10 + 2*mode for the three legal key sizes
  always_comb begin
    mode_nr = 4'd10 + {1'b0, mode, 1'b0};
    accept  = (state == IDLE) && start && !abort && (mode != 2'b11);
    illegal = (state == IDLE) && start && !abort && (mode == 2'b11);
    at_last = dir_q ? (idx_q == 4'd0) : (idx_q == nr_q);
    step    = !abort && ((state == INIT) || ((state == ROUND) && !at_last));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = INIT;
      INIT:    state_nxt = abort ? IDLE : ROUND;
      ROUND:   if (abort) state_nxt = IDLE;
               else if (at_last) state_nxt = DONE;
      DONE:    if (abort || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    rnd_en    = (state == INIT) || (state == ROUND);
    rnd_first = (state == INIT);
    rnd_last  = (state == ROUND) && at_last;
    out_valid = (state == DONE);
    nr        = nr_q;
    rnd_idx   = idx_q;
    dir       = dir_q;
    err       = err_q;
  end

  // The last round holds the index, so the counter can never wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nr_q  <= 4'd10;
      idx_q <= 4'd0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= illegal;
      if (accept) begin
        nr_q  <= mode_nr;
        dir_q <= decrypt;
        idx_q <= decrypt ? mode_nr : 4'd0;
      end else if (step) begin
        idx_q <= dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
      end
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: a per-cycle behavioural model checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, decrypt, abort, out_ready;
  logic [1:0] mode;
  logic       in_ready, rnd_en, rnd_first, rnd_last, dir, out_valid, err;
  logic [3:0] nr, rnd_idx;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: an operation is a run of steps; step 0 is the key-only step,
  // steps 1..Nr are rounds, step Nr+1 is the result-holding phase.
  bit m_armed  = 1'b0;
  bit m_active = 1'b0;
  bit m_err    = 1'b0;
  bit m_fresh  = 1'b1;
  bit m_dir    = 1'b0;
  int m_step   = 0;
  int m_nr     = 10;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .decrypt(decrypt),
    .abort(abort), .out_ready(out_ready), .in_ready(in_ready), .nr(nr),
    .rnd_idx(rnd_idx), .rnd_en(rnd_en), .rnd_first(rnd_first),
    .rnd_last(rnd_last), .dir(dir), .out_valid(out_valid), .err(err)
  );

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {3'b000, act}, {3'b000, exp});
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] m, input logic d,
                               input logic a, input logic o, input logic r);
    start = s; mode = m; decrypt = d; abort = a; out_ready = o; rst = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_armed = 1'b1; m_active = 1'b0; m_nr = 10; m_dir = 1'b0;
      m_err = 1'b0; m_fresh = 1'b1; m_step = 0;
    end else if (m_armed) begin
      if (!m_active) begin
        m_err = start && !abort && (mode == 2'b11);
        if (start && !abort && (mode != 2'b11)) begin
          m_active = 1'b1; m_step = 0; m_nr = 10 + 2 * int'(mode);
          m_dir = decrypt; m_fresh = 1'b0;
        end
      end else begin
        m_err = 1'b0;
        if (abort) m_active = 1'b0;
        else if (m_step <= m_nr) m_step++;
        else if (out_ready) m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      checkBit("in_ready", in_ready, !m_active);
      checkOutput("nr", nr, 4'(m_nr));
      checkBit("dir", dir, m_dir);
      checkBit("rnd_en", rnd_en, m_active && (m_step <= m_nr));
      checkBit("rnd_first", rnd_first, m_active && (m_step == 0));
      checkBit("rnd_last", rnd_last, m_active && (m_step == m_nr));
      checkBit("out_valid", out_valid, m_active && (m_step == m_nr + 1));
      checkBit("err", err, m_err);
      if (m_active && (m_step <= m_nr))
        checkOutput("rnd_idx", rnd_idx, 4'(m_dir ? (m_nr - m_step) : m_step));
      else if (!m_active && m_fresh)
        checkOutput("rnd_idx_rst", rnd_idx, 4'd0);
    end
  end

  // AES-128 cipher: indices 0..10, last at cycle 11, result at cycle 12 only
  task automatic runEncCheck();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    for (int c = 1; c <= 13; c++) begin
      applyStimulus(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkBit("enc_en", rnd_en, c <= 11);
      if (c <= 11) checkOutput("enc_idx", rnd_idx, 4'(c - 1));
      checkBit("enc_first", rnd_first, c == 1);
      checkBit("enc_last", rnd_last, c == 11);
      checkBit("enc_valid", out_valid, c == 12);
      checkBit("enc_ready", in_ready, c == 13);
      stepCycle();
    end
  endtask

  initial begin
    int pulses;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkBit("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_nr", nr, 4'd10);
    checkOutput("rst_idx", rnd_idx, 4'd0);
    checkBit("rst_valid", out_valid, 1'b0);
    stepCycle();

    runEncCheck();

    // AES-256 inverse cipher: indices 14 down to 0, 15 load strobes
    pulses = 0;
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    stepCycle();
    for (int c = 1; c <= 17; c++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      if (rnd_en === 1'b1) pulses++;
      if (c <= 15) checkOutput("dec_idx", rnd_idx, 4'(15 - c));
      checkBit("dec_first", rnd_first, c == 1);
      checkBit("dec_last", rnd_last, c == 15);
      checkBit("dec_valid", out_valid, c == 16);
      stepCycle();
    end
    checkOutput("dec_pulses", 4'(pulses), 4'd15);

    // AES-192 with a stalled consumer and a stray start during the hold
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    for (int c = 1; c <= 21; c++) begin
      applyStimulus((c >= 14) && (c <= 18), 2'b00, 1'b0, 1'b0, c >= 19, 1'b0);
      @(negedge clk);
      checkBit("hold_en", rnd_en, c <= 13);
      checkBit("hold_valid", out_valid, (c >= 14) && (c <= 19));
      checkBit("hold_ready", in_ready, c >= 20);
      stepCycle();
    end

    // Illegal mode: one-cycle error, nothing starts, latched values kept
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    stepCycle();
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkBit("ill_err", err, c == 1);
      checkBit("ill_ready", in_ready, 1'b1);
      checkBit("ill_en", rnd_en, 1'b0);
      checkOutput("ill_nr", nr, 4'd12);
      checkBit("ill_dir", dir, 1'b0);
      stepCycle();
    end

    // Abort in the 4th round, then a clean operation
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, c == 5, 1'b1, 1'b0);
      @(negedge clk);
      checkBit("abt_en", rnd_en, c <= 5);
      checkBit("abt_ready", in_ready, c >= 6);
      checkBit("abt_valid", out_valid, 1'b0);
      stepCycle();
    end
    runEncCheck();

    // Reset mid-round, then start together with abort
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    stepCycle();
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, c == 5);
      @(negedge clk);
      if (c == 6) begin
        checkBit("mrst_ready", in_ready, 1'b1);
        checkOutput("mrst_nr", nr, 4'd10);
        checkOutput("mrst_idx", rnd_idx, 4'd0);
        checkBit("mrst_dir", dir, 1'b0);
        checkBit("mrst_en", rnd_en, 1'b0);
        checkBit("mrst_first", rnd_first, 1'b0);
        checkBit("mrst_last", rnd_last, 1'b0);
        checkBit("mrst_valid", out_valid, 1'b0);
        checkBit("mrst_err", err, 1'b0);
      end
      stepCycle();
    end
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkBit("sa_ready", in_ready, 1'b1);
    checkBit("sa_en", rnd_en, 1'b0);
    checkBit("sa_err", err, 1'b0);
    stepCycle();

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 99) < 3,
                    1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
      stepCycle();
    end

    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
